// File: rtl/mult_accum.sv
// ---------------------------------------------------------------------------
// mult_accum
//   Accumulates a group of unsigned 8-bit products from an upstream 4x4
//   multiplier into an ACC_W-bit sum. The product is zero-extended before it
//   is added. A group ends on a beat marked in_last, or when the group reaches
//   MAX_TERMS terms. The finished result is then held until the downstream
//   accepts it.
//
//   Optional build macro: MULT_ACCUM_SAT_EN
//     defined   -> on overflow the accumulator clamps to 2^ACC_W-1
//     undefined -> the accumulator wraps modulo 2^ACC_W (no clamp logic)
//
// Parameters
//   ACC_W      accumulator/result width, 8..16
//   MAX_TERMS  maximum products per group, 1..31
//
// Ports
//   clk        sole clock; all state changes on the rising edge
//   rst        asynchronous active-high reset
//   in_prod    unsigned product to accumulate
//   in_valid   in_prod is valid this cycle
//   in_last    marks the final term of the group
//   in_ready   block accepts a beat this cycle (high in ACC)
//   out_sum    running sum (ACC) / group result (HOLD)
//   out_count  number of terms accumulated
//   out_ovf    sticky overflow flag for the current group
//   out_valid  result valid (high in HOLD)
//   out_ready  downstream accepts the result
//   dbg_state  current FSM state (0 = ACC, 1 = HOLD)
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. A valid signal stays asserted with its payload stable until the
// transfer happens. Ready depends only on the FSM state, never on valid.
// ---------------------------------------------------------------------------
module mult_accum #(
  parameter int ACC_W     = 12,
  parameter int MAX_TERMS = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       in_prod,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [4:0]       out_count,
  output logic             out_ovf,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             dbg_state
);

  typedef enum logic {
    ST_ACC  = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  state_t           state_q;
  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] acc_d;
  logic [4:0]       cnt_q;
  logic [4:0]       cnt_d;
  logic             ovf_q;

  logic             accept;
  logic             term_end;
  logic [ACC_W:0]   sum_ext;
  logic             carry;

  assign accept   = in_valid && (state_q == ST_ACC);
  // The group closes on an explicit last beat, or on the beat that brings the
  // count up to MAX_TERMS.
  assign term_end = in_last || (cnt_q == 5'(MAX_TERMS - 1));

  // The extra top bit of the sum is the carry-out. It is the overflow indication.
  assign sum_ext = {1'b0, acc_q} + (ACC_W + 1)'(in_prod);
  assign carry   = sum_ext[ACC_W];
  assign cnt_d   = cnt_q + 5'd1;

  always_comb begin
    acc_d = sum_ext[ACC_W-1:0];
`ifdef MULT_ACCUM_SAT_EN
    // A clamped accumulator stays at full scale. Adding zero keeps it there,
    // and any non-zero term carries out and clamps it again.
    if (carry) begin
      acc_d = '1;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_ACC;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_ACC: begin
          if (accept) begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_q | carry;
            if (term_end) begin
              state_q <= ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          // in_ready is low in HOLD, so no beat can land on the handshake
          // edge. The next group starts from a clean slate.
          if (out_ready) begin
            state_q <= ST_ACC;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_ACC;
        end
      endcase
    end
  end

  assign in_ready  = (state_q == ST_ACC);
  assign out_valid = (state_q == ST_HOLD);
  assign out_sum   = acc_q;
  assign out_count = cnt_q;
  assign out_ovf   = ovf_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mult_accum.sv
// ---------------------------------------------------------------------------
// tb_mult_accum
//   Directed bench for mult_accum. Instance a_dut uses the default parameters.
//   Instance b_dut uses ACC_W=8 and MAX_TERMS=3, so that overflow, wrap or
//   clamp, and the term-count limit can be reached with a few beats.
//   Expected values are hand-computed constants. For b_dut they depend on
//   MULT_ACCUM_SAT_EN.
// ---------------------------------------------------------------------------
module tb_mult_accum;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- instance A (defaults) ----------------
  logic [7:0]  a_prod = '0;
  logic        a_valid = 1'b0, a_last = 1'b0, a_oready = 1'b0;
  logic        a_iready, a_ovf, a_ovalid, a_dbg;
  logic [11:0] a_sum;
  logic [4:0]  a_cnt;

  mult_accum a_dut (
    .clk(clk), .rst(rst), .in_prod(a_prod), .in_valid(a_valid), .in_last(a_last),
    .in_ready(a_iready), .out_sum(a_sum), .out_count(a_cnt), .out_ovf(a_ovf),
    .out_valid(a_ovalid), .out_ready(a_oready), .dbg_state(a_dbg)
  );

  // ---------------- instance B (ACC_W=8, MAX_TERMS=3) ----------------
  logic [7:0]  b_prod = '0;
  logic        b_valid = 1'b0, b_last = 1'b0, b_oready = 1'b0;
  logic        b_iready, b_ovf, b_ovalid, b_dbg;
  logic [7:0]  b_sum;
  logic [4:0]  b_cnt;

  mult_accum #(.ACC_W(8), .MAX_TERMS(3)) b_dut (
    .clk(clk), .rst(rst), .in_prod(b_prod), .in_valid(b_valid), .in_last(b_last),
    .in_ready(b_iready), .out_sum(b_sum), .out_count(b_cnt), .out_ovf(b_ovf),
    .out_valid(b_ovalid), .out_ready(b_oready), .dbg_state(b_dbg)
  );

`ifdef MULT_ACCUM_SAT_EN
  localparam logic [7:0] EXP_B_225X2 = 8'd255;  // 450 clamps
  localparam logic [7:0] EXP_B_100X3 = 8'd255;  // 300 clamps
  localparam logic [7:0] EXP_B_STICK = 8'd255;  // clamped, stays clamped
`else
  localparam logic [7:0] EXP_B_225X2 = 8'd194;  // 450 - 256
  localparam logic [7:0] EXP_B_100X3 = 8'd44;   // 300 - 256
  localparam logic [7:0] EXP_B_STICK = 8'd45;   // 300 - 256 + 1
`endif

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Present one beat, let one rising edge pass, then sample 1 time unit later.
  task automatic beat_a(input logic [7:0] prod, input logic last);
    a_prod = prod; a_last = last; a_valid = 1'b1;
    @(posedge clk); #1;
    a_valid = 1'b0; a_last = 1'b0;
  endtask

  task automatic beat_b(input logic [7:0] prod, input logic last);
    b_prod = prod; b_last = last; b_valid = 1'b1;
    @(posedge clk); #1;
    b_valid = 1'b0; b_last = 1'b0;
  endtask

  task automatic drain_a(input string tag);
    check({tag, "_vld_before_drain"}, a_ovalid, 1);
    a_oready = 1'b1;
    @(posedge clk); #1;
    a_oready = 1'b0;
    check({tag, "_vld_after_drain"}, a_ovalid, 0);
    check({tag, "_rdy_after_drain"}, a_iready, 1);
  endtask

  task automatic drain_b(input string tag);
    check({tag, "_vld_before_drain"}, b_ovalid, 1);
    b_oready = 1'b1;
    @(posedge clk); #1;
    b_oready = 1'b0;
    check({tag, "_vld_after_drain"}, b_ovalid, 0);
    check({tag, "_cnt_after_drain"}, b_cnt, 0);
  endtask

  // ---------------- directed tests ----------------
  initial begin
    #12;
    check("rst_valid", a_ovalid, 0);
    check("rst_iready", a_iready, 1);
    check("rst_sum", a_sum, 0);
    check("rst_count", a_cnt, 0);
    check("rst_ovf", a_ovf, 0);
    check("rst_state", a_dbg, 0);
    @(negedge clk); rst = 1'b0;

    // Two-term group, 12 + 36
    beat_a(8'd12, 1'b0);
    check("g1_run_sum", a_sum, 12);
    check("g1_run_cnt", a_cnt, 1);
    check("g1_run_vld", a_ovalid, 0);
    beat_a(8'd36, 1'b1);
    check("g1_vld", a_ovalid, 1);
    check("g1_sum", a_sum, 48);
    check("g1_cnt", a_cnt, 2);
    check("g1_ovf", a_ovf, 0);
    check("g1_iready", a_iready, 0);

    // Backpressure in HOLD while a beat is offered
    a_prod = 8'd7; a_valid = 1'b1; a_oready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_sum", a_sum, 48);
      check("bp_cnt", a_cnt, 2);
      check("bp_iready", a_iready, 0);
      check("bp_vld", a_ovalid, 1);
    end
    a_oready = 1'b1;
    @(posedge clk); #1;
    a_oready = 1'b0; a_valid = 1'b0;
    check("hs_vld", a_ovalid, 0);
    check("hs_sum_no_absorb", a_sum, 0);
    check("hs_cnt_no_absorb", a_cnt, 0);
    check("hs_iready", a_iready, 1);
    beat_a(8'd9, 1'b0);
    check("post_hs_sum", a_sum, 9);
    check("post_hs_cnt", a_cnt, 1);
    beat_a(8'd0, 1'b1);
    check("post_hs_grp_sum", a_sum, 9);
    check("post_hs_grp_cnt", a_cnt, 2);
    drain_a("post_hs");

    // MAX_TERMS limit: 16 x 225 with no last
    for (int i = 0; i < 16; i++) begin
      beat_a(8'd225, 1'b0);
      if (i == 14) check("max15_vld", a_ovalid, 0);
    end
    check("max_vld", a_ovalid, 1);
    check("max_sum", a_sum, 3600);
    check("max_cnt", a_cnt, 16);
    check("max_ovf", a_ovf, 0);
    check("max_iready", a_iready, 0);
    drain_a("max");

    // Reset in the middle of a group
    beat_a(8'd10, 1'b0);
    beat_a(8'd10, 1'b0);
    beat_a(8'd10, 1'b0);
    check("mid_sum", a_sum, 30);
    check("mid_cnt", a_cnt, 3);
    #2 rst = 1'b1;
    #1;
    check("arst_sum", a_sum, 0);
    check("arst_cnt", a_cnt, 0);
    check("arst_vld", a_ovalid, 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    check("arst_idle_vld", a_ovalid, 0);
    beat_a(8'd5, 1'b1);
    check("arst_next_vld", a_ovalid, 1);
    check("arst_next_sum", a_sum, 5);
    check("arst_next_cnt", a_cnt, 1);
    drain_a("arst");

    // Zero-valued last beat as the first term
    beat_a(8'd0, 1'b1);
    check("zero_vld", a_ovalid, 1);
    check("zero_sum", a_sum, 0);
    check("zero_cnt", a_cnt, 1);
    check("zero_ovf", a_ovf, 0);
    drain_a("zero");

    // 8-bit accumulator overflow: 225 + 225
    beat_b(8'd225, 1'b0);
    check("b1_run_ovf", b_ovf, 0);
    beat_b(8'd225, 1'b1);
    check("b1_vld", b_ovalid, 1);
    check("b1_sum", b_sum, EXP_B_225X2);
    check("b1_ovf", b_ovf, 1);
    check("b1_cnt", b_cnt, 2);
    drain_b("b1");
    check("b1_ovf_cleared", b_ovf, 0);

    // MAX_TERMS=3 closes the group. The third term overflows.
    beat_b(8'd100, 1'b0);
    beat_b(8'd100, 1'b0);
    check("b2_run_vld", b_ovalid, 0);
    check("b2_run_sum", b_sum, 200);
    beat_b(8'd100, 1'b0);
    check("b2_vld", b_ovalid, 1);
    check("b2_sum", b_sum, EXP_B_100X3);
    check("b2_ovf", b_ovf, 1);
    check("b2_cnt", b_cnt, 3);
    drain_b("b2");

    // Overflow flag stays set after a later non-overflowing term
    beat_b(8'd200, 1'b0);
    beat_b(8'd100, 1'b0);
    check("b3_mid_ovf", b_ovf, 1);
    beat_b(8'd1, 1'b1);
    check("b3_sum", b_sum, EXP_B_STICK);
    check("b3_ovf", b_ovf, 1);
    drain_b("b3");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mult_accum.md
MULT_ACCUM -- requirements
Module: mult_accum

Interface
REQ-001 SHALL have parameter ACC_W, default 12, accumulator/result width in bits (legal range 8..16).
REQ-002 SHALL have parameter MAX_TERMS, default 16, maximum products per accumulation group (legal range 1..31).
REQ-003 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port in_prod, input, 8, unsigned 8-bit product from the upstream 4x4 Dadda multiplier.
REQ-006 SHALL have port in_valid, input, 1, in_prod valid this cycle.
REQ-007 SHALL have port in_last, input, 1, qualifies the beat as the final term of the group.
REQ-008 SHALL have port in_ready, output, 1, the block accepts a beat this cycle.
REQ-009 SHALL have port out_sum, output, ACC_W, accumulated group result.
REQ-010 SHALL have port out_count, output, 5, number of terms in the result.
REQ-011 SHALL have port out_ovf, output, 1, an overflow occurred in this group (sticky per group).
REQ-012 SHALL have port out_valid, output, 1, result valid.
REQ-013 SHALL have port out_ready, input, 1, downstream accepts the result.

Function
REQ-014 SHALL implement a two-state FSM: ACC (accepting terms) and HOLD (presenting the result).
REQ-015 SHALL drive in_ready=1 in ACC and in_ready=0 in HOLD, combinationally from state only.
REQ-016 SHALL accept a beat iff in_valid && in_ready; a non-accepted beat has no effect.
REQ-017 On accept, SHALL update acc <= acc + zero-extended in_prod and cnt <= cnt + 1.
REQ-018 On accept with in_last=1, or with cnt == MAX_TERMS-1, SHALL move to HOLD on the same edge; the result is visible the next cycle, with latency 1 cycle from the last accepted beat.
REQ-019 In HOLD, SHALL hold out_valid=1 and keep out_sum, out_count and out_ovf stable until out_valid && out_ready.
REQ-020 On the output handshake, SHALL clear acc, cnt and the overflow flag and return to ACC; in_ready is asserted the following cycle, with no new beat accepted on the handshake cycle.
REQ-021 In ACC, SHALL drive out_valid=0, and out_sum, out_count and out_ovf SHALL show the running values.
REQ-022 An in_last beat with in_prod=0 SHALL still count as a term.
REQ-023 SHALL detect overflow when the ACC_W+1-bit sum exceeds 2^ACC_W-1, and SHALL set the sticky flag.
REQ-024 Without saturation, SHALL wrap acc modulo 2^ACC_W.

Reset
REQ-025 rst=1 SHALL asynchronously force state=ACC, acc=0, cnt=0 and ovf=0, so that out_valid=0, in_ready=1, out_sum=0, out_count=0 and out_ovf=0.
REQ-026 rst asserted mid-group or in HOLD SHALL discard the partial or pending result; no out_valid after release until a new group completes.
REQ-027 Release SHALL be sampled on clk; the first beat can be accepted on the first edge with rst=0.

Configuration
REQ-028 Macro MULT_ACCUM_SAT_EN defined: on overflow, SHALL clamp acc to 2^ACC_W-1, and later accepts SHALL leave it clamped; out_ovf behaves the same.
REQ-029 Macro MULT_ACCUM_SAT_EN undefined: SHALL wrap per REQ-024, with no clamp logic present.

Verification
REQ-030 Default params; beats 12 (4*3), then 36 (4*9, last) -> out_valid one cycle after the 2nd accept, out_sum=48, out_count=2, out_ovf=0.
REQ-031 Default params; 16 beats of 225 (15*15), never last -> HOLD after the 16th, out_sum=3600, out_count=16, out_ovf=0, in_ready=0.
REQ-032 ACC_W=8; beats 225, 225 (last) -> without SAT_EN out_sum=194, out_ovf=1; with SAT_EN out_sum=255, out_ovf=1.
REQ-033 Result 48 pending with out_ready=0 for 5 cycles while in_valid=1 -> out_sum stays 48, in_ready=0, no beat lost or absorbed; out_ready=1 -> returns to ACC, next beat of 9 gives running out_sum=9.
REQ-034 rst pulsed after 3 accepted beats (sum 30) -> immediately out_sum=0, out_count=0, out_valid=0; next group 5 (last) -> out_sum=5, out_count=1.
REQ-035 in_valid=1, in_last=1, in_prod=0 as the first beat -> out_valid, out_sum=0, out_count=1.
